// File: rtl/piso_rr_scheduler.sv
// Shares one PISO between NUM_REQ word requesters: round-robin grant, load strobe, serial window, gap.
// Build option: define PISO_SCHED_PRIORITY_EN for fixed lowest-index-wins priority (no rr pointer).
module piso_rr_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int GAP_CYCLES = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          piso_enable,
    output logic [DATA_WIDTH-1:0]         piso_data,
    output logic                          frame_valid,
    output logic [$clog2(NUM_REQ)-1:0]    frame_owner,
    output logic                          busy
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

    state_t                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [GAP_W-1:0]        gap_q;
    logic                    piso_enable_q;
    logic [DATA_WIDTH-1:0]   piso_data_q;
    logic [IDX_W-1:0]        frame_owner_q;
    logic                    frame_valid_q;

    logic                    grant_vld;
    logic [IDX_W-1:0]        grant_idx;
    logic [DATA_WIDTH-1:0]   grant_data;

`ifdef PISO_SCHED_PRIORITY_EN
    // Descending scan so the lowest valid index is the one left standing.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                grant_vld = 1'b1;
                grant_idx = IDX_W'(i);
            end
        end
    end
`else
    logic [IDX_W-1:0] rr_ptr_q;
    logic [IDX_W-1:0] rr_ptr_d;

    // Descending offset scan from the pointer: the smallest wrapped offset wins.
    always_comb begin
        int j;
        j         = 0;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = int'(rr_ptr_q) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (req_valid[j]) begin
                grant_vld = 1'b1;
                grant_idx = IDX_W'(j);
            end
        end
    end

    assign rr_ptr_d = (grant_idx == IDX_LAST) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_q <= '0;
        end else if (state_q == IDLE && grant_vld) begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IDX_W'(i)) grant_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Ready is gated by reset so every output is low while reset is held.
    always_comb begin
        req_ready = '0;
        if (reset && state_q == IDLE && grant_vld) req_ready[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            gap_q         <= '0;
            piso_enable_q <= 1'b0;
            piso_data_q   <= '0;
            frame_owner_q <= '0;
            frame_valid_q <= 1'b0;
        end else begin
            // One cycle behind SHIFT, matching the PISO output register.
            frame_valid_q <= (state_q == SHIFT);
            piso_enable_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_vld) begin
                        piso_data_q   <= grant_data;
                        frame_owner_q <= grant_idx;
                        piso_enable_q <= 1'b1;
                        state_q       <= LOAD;
                    end
                end
                LOAD: begin
                    cnt_q   <= '0;
                    state_q <= SHIFT;
                end
                SHIFT: begin
                    if (cnt_q == CNT_LAST) begin
                        gap_q   <= '0;
                        state_q <= GAP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_q == GAP_LAST) state_q <= IDLE;
                    else gap_q <= gap_q + 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign piso_enable = piso_enable_q;
    assign piso_data   = piso_data_q;
    assign frame_owner = frame_owner_q;
    assign frame_valid = frame_valid_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_piso_rr_scheduler.sv
// Bench for piso_rr_scheduler: directed scenarios plus random requesters against a timeline model.
module tb_piso_rr_scheduler;
    localparam int NR     = 4;
    localparam int DW     = 8;
    localparam int GAP    = 1;
    localparam int IW     = $clog2(NR);
    localparam int PERIOD = DW + GAP + 2;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR*DW-1:0]  req_data = '0;
    logic [NR-1:0]     req_ready;
    logic              piso_enable;
    logic [DW-1:0]     piso_data;
    logic              frame_valid;
    logic [IW-1:0]     frame_owner;
    logic              busy;

    piso_rr_scheduler #(.NUM_REQ(NR), .DATA_WIDTH(DW), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .piso_enable(piso_enable), .piso_data(piso_data),
        .frame_valid(frame_valid), .frame_owner(frame_owner), .busy(busy)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model: every output follows from the cycle of the last grant.
    int            cyc = 0;
    int            g = -1000;
    int            m_ptr = 0;
    int            m_owner = 0;
    logic [DW-1:0] m_word = '0;
    logic [NR-1:0] last_ready = '0;
    int            og[$];
    int            ogc[$];
    int            ser_q[$];
    int            en_cnt = 0;
    int            exp_bits[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    int            exp_own3[5] = '{0, 1, 2, 3, 0};
    int            exp_own6[4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int pick(input logic [NR-1:0] v);
`ifdef PISO_SCHED_PRIORITY_EN
        for (int k = 0; k < NR; k++) if (v[k]) return k;
`else
        for (int k = 0; k < NR; k++) if (v[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
`endif
        return -1;
    endfunction

    task automatic check_cycle();
        int            d;
        int            w;
        logic [NR-1:0] exp_ready;
        logic          exp_busy;
        exp_ready = '0;
        w = -1;
        if (!reset) begin
            g = -1000; m_ptr = 0; m_word = '0; m_owner = 0;
        end
        d = cyc - g;
        exp_busy = (d >= 1 && d <= PERIOD - 1);
        if (reset && !exp_busy) begin
            w = pick(req_valid);
            if (w >= 0) exp_ready[w] = 1'b1;
        end
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("piso_enable", 32'(piso_enable), 32'(d == 1));
        chk("frame_valid", 32'(frame_valid), 32'(d >= 3 && d <= DW + 2));
        chk("piso_data", 32'(piso_data), 32'(m_word));
        chk("frame_owner", 32'(frame_owner), 32'(m_owner));
        for (int i = 0; i < NR; i++) begin
            if (req_ready[i]) begin
                og.push_back(i);
                ogc.push_back(cyc);
            end
        end
        if (frame_valid) ser_q.push_back(int'(piso_data[ser_q.size() % DW]));
        if (piso_enable) en_cnt++;
        last_ready = req_ready;
        if (w >= 0) begin
            g = cyc; m_word = req_data[w*DW +: DW]; m_owner = w; m_ptr = (w + 1) % NR;
        end
        cyc++;
    endtask

    // Check at the falling edge, then drive just after the rising edge; granted words retire.
    task automatic tick();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
        req_valid = req_valid & ~last_ready;
    endtask

    task automatic raise(input int i, input logic [DW-1:0] d);
        if (!req_valid[i]) begin
            req_valid[i] = 1'b1;
            req_data[i*DW +: DW] = d;
        end
    endtask

    task automatic clear_obs();
        og.delete(); ogc.delete(); ser_q.delete(); en_cnt = 0;
    endtask

    task automatic reset_pulse();
        reset = 1'b0;
        req_valid = '0;
        tick();
        tick();
        reset = 1'b1;
        clear_obs();
    endtask

    initial begin
        // Reset mid-SHIFT aborts the frame; afterwards the pointer restarts at 0.
        reset_pulse();
        raise(0, 8'h3C);
        tick();
        repeat (4) tick();
        chk("t1_busy_mid_shift", 32'(busy), 32'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        clear_obs();
        repeat (3) tick();
        raise(1, 8'h11);
        raise(0, 8'h22);
        tick();
        chk("t1_grant_after_reset", 32'(og.size() > 0 ? og[0] : -1), 32'd0);
        repeat (2 * PERIOD) tick();

        // Single requester, word A5, LSB first.
        reset_pulse();
        raise(0, 8'hA5);
        repeat (PERIOD + 2) tick();
        chk("t2_fv_cycles", 32'(ser_q.size()), 32'd8);
        for (int k = 0; k < 8; k++) begin
            if (k < ser_q.size()) chk($sformatf("t2_bit%0d", k), 32'(ser_q[k]), 32'(exp_bits[k]));
            else chk($sformatf("t2_bit%0d_missing", k), 32'(-1), 32'(exp_bits[k]));
        end
        chk("t2_enable_pulses", 32'(en_cnt), 32'd1);

        // All requesters continuously valid.
        reset_pulse();
        for (int c = 0; c < 5 * PERIOD; c++) begin
            for (int i = 0; i < NR; i++) raise(i, DW'($urandom));
            tick();
        end
        req_valid = '0;
        repeat (PERIOD) tick();
        chk("t3_grant_count", 32'(og.size() >= 5), 32'd1);
        for (int k = 0; k < 5; k++) begin
            if (k < og.size()) chk($sformatf("t3_owner%0d", k), 32'(og[k]), 32'(exp_own3[k]));
            if (k > 0 && k < ogc.size())
                chk($sformatf("t3_spacing%0d", k), 32'(ogc[k] - ogc[k-1]), 32'(PERIOD));
        end

        // Request arriving during another frame's SHIFT waits for the next IDLE.
        reset_pulse();
        raise(0, 8'h5A);
        repeat (3) tick();
        raise(2, 8'hC3);
        repeat (2 * PERIOD) tick();
        chk("t4_grant_count", 32'(og.size()), 32'd2);
        if (og.size() >= 2) begin
            chk("t4_second_owner", 32'(og[1]), 32'd2);
            chk("t4_wait", 32'(ogc[1] - ogc[0]), 32'(PERIOD));
        end

        // Request withdrawn while busy is never granted.
        reset_pulse();
        raise(0, 8'h0F);
        repeat (2) tick();
        raise(1, 8'hF0);
        repeat (3) tick();
        req_valid[1] = 1'b0;
        repeat (2 * PERIOD) tick();
        chk("t5_enable_pulses", 32'(en_cnt), 32'd1);
        chk("t5_grant_count", 32'(og.size()), 32'd1);

        // Requesters 1 and 3 held valid.
`ifdef PISO_SCHED_PRIORITY_EN
        exp_own6 = '{1, 1, 1, 1};
`else
        exp_own6 = '{1, 3, 1, 3};
`endif
        reset_pulse();
        for (int c = 0; c < 4 * PERIOD; c++) begin
            raise(1, DW'($urandom));
            raise(3, DW'($urandom));
            tick();
        end
        req_valid = '0;
        repeat (PERIOD) tick();
        chk("t6_grant_count", 32'(og.size() >= 4), 32'd1);
        for (int k = 0; k < 4; k++) begin
            if (k < og.size()) chk($sformatf("t6_owner%0d", k), 32'(og[k]), 32'(exp_own6[k]));
        end

        // Random requesters, including early withdrawals.
        reset_pulse();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!req_valid[i] && $urandom_range(3) == 0) raise(i, DW'($urandom));
                else if (req_valid[i] && $urandom_range(15) == 0) req_valid[i] = 1'b0;
            end
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
